// File: rtl/serial_comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude/equality comparator.
// Signed operation is selected at build time with SERIAL_COMPARATOR_SIGNED_EN.
package serial_comparator_pkg;

    localparam int DEFAULT_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One where both operand bits agree
    function automatic logic bit_match(input logic x, input logic y);
        return x ~^ y;
    endfunction

endpackage

// File: rtl/serial_comparator_compare_bit.sv
// One step of the LSB-first compare recurrence; the MSB step flips the
// less-than sense when SERIAL_COMPARATOR_SIGNED_EN is defined.
module compare_bit
    import serial_comparator_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic eq_in,
    input  logic lt_in,
    input  logic msb,
    output logic eq_out,
    output logic lt_out
);

`ifdef SERIAL_COMPARATOR_SIGNED_EN
    localparam logic SIGNED_MODE = 1'b1;
`else
    localparam logic SIGNED_MODE = 1'b0;
`endif

    logic match_s;
    logic signed_msb_s;
    logic lt_here_s;

    // A differing higher bit decides the order; equal bits keep the lower verdict
    always_comb begin
        match_s      = bit_match(a_i, b_i);
        signed_msb_s = msb & SIGNED_MODE;
        if (signed_msb_s) begin
            lt_here_s = a_i & ~b_i;
        end else begin
            lt_here_s = ~a_i & b_i;
        end
        eq_out = eq_in & match_s;
        lt_out = lt_here_s | (match_s & lt_in);
    end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial comparator: accepts a/b, walks N bits LSB first, reports equals
// and less_than with a valid/ready handshake. Signed mode: SERIAL_COMPARATOR_SIGNED_EN.
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int N = DEFAULT_N
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         equals,
    output logic         less_than,
    output logic         busy
);

    localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_t           state_r;
    state_t           state_s;
    logic [N-1:0]     a_sh_r;
    logic [N-1:0]     b_sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             eq_acc_r;
    logic             lt_acc_r;
    logic             eq_r;
    logic             lt_r;
    logic             accept_s;
    logic             last_bit_s;
    logic             eq_bit_s;
    logic             lt_bit_s;

    assign accept_s   = (state_r == IDLE) & i_valid;
    assign last_bit_s = (cnt_r == LAST_BIT);

    compare_bit u_compare_bit (
        .a_i    (a_sh_r[0]),
        .b_i    (b_sh_r[0]),
        .eq_in  (eq_acc_r),
        .lt_in  (lt_acc_r),
        .msb    (last_bit_s),
        .eq_out (eq_bit_s),
        .lt_out (lt_bit_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        i_ready = 1'b0;
        busy    = 1'b0;
        o_valid = 1'b0;
        case (state_r)
            IDLE:    i_ready = 1'b1;
            RUN:     busy    = 1'b1;
            DONE:    o_valid = 1'b1;
            default: i_ready = 1'b0;
        endcase
    end

    // Operand shifters, bit counter, accumulators and the held result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh_r   <= {N{1'b0}};
            b_sh_r   <= {N{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            eq_acc_r <= 1'b0;
            lt_acc_r <= 1'b0;
            eq_r     <= 1'b0;
            lt_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        cnt_r    <= {CNT_W{1'b0}};
                        eq_acc_r <= 1'b1;
                        lt_acc_r <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[N-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[N-1:1]};
                    eq_acc_r <= eq_bit_s;
                    lt_acc_r <= lt_bit_s;
                    if (last_bit_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        eq_r  <= eq_bit_s;
                        lt_r  <= lt_bit_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign equals    = eq_r;
    assign less_than = lt_r;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed-table and random bench for serial_comparator (N=32); expectations
// follow the build's SERIAL_COMPARATOR_SIGNED_EN setting.
module tb_serial_comparator;

    localparam int N = 32;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] av;
        logic [N-1:0] bv;
        logic         exp_eq;
        logic         exp_lt_s;
        logic         exp_lt_u;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         o_valid;
    logic         o_ready;
    logic         equals;
    logic         less_than;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_comparator #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .a         (a),
        .b         (b),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .equals    (equals),
        .less_than (less_than),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_cmp(input logic [N-1:0] av, input logic [N-1:0] bv, output int acc_cyc);
        int w;
        w = 0;
        while (i_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_wait", 32'(w < 100), 32'd1);
        a       = av;
        b       = bv;
        i_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        i_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_result(output int lat);
        logic run_ok;
        run_ok = 1'b1;
        lat    = 0;
        while (o_valid !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1 || i_ready !== 1'b0) run_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(N));
        check("busy_in_run", 32'(run_ok), 32'd1);
        check("i_ready_in_done", 32'(i_ready), 32'd0);
        check("eq_lt_exclusive", 32'(equals & less_than), 32'd0);
    endtask

    initial begin
        vec_t         vecs [11];
        int           lat, c1, c2;
        logic         e0, l0, saw_valid;
        logic [N-1:0] ra, rb;
        logic         rexp;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'd38273,     32'd1000,      1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'd1000,      32'd38273,     1'b0, 1'b1, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'd5,         32'd5,         1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'd1,         32'd0,         1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};

        rst = 1'b0; i_valid = 1'b0; o_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_ready", 32'(i_ready), 32'd1);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_equals", 32'(equals), 32'd0);
        check("rst_less_than", 32'(less_than), 32'd0);

        // First vector is accepted on the first edge after reset release
        rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            start_cmp(vecs[i].av, vecs[i].bv, c1);
            wait_result(lat);
            check($sformatf("vec%0d_equals", i), 32'(equals), 32'(vecs[i].exp_eq));
            check($sformatf("vec%0d_less_than", i), 32'(less_than),
                  32'(SIGNED_BUILD ? vecs[i].exp_lt_s : vecs[i].exp_lt_u));
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle_after", i), 32'(i_ready), 32'd1);
            check($sformatf("vec%0d_held_eq", i), 32'(equals), 32'(vecs[i].exp_eq));
        end

        // Back-to-back with o_ready held high: 34-cycle accept spacing
        start_cmp(32'd38273, 32'd1000, c1);
        wait_result(lat);
        check("b2b_first_lt", 32'(less_than), 32'd0);
        start_cmp(32'd1000, 32'd38273, c2);
        check("b2b_spacing", 32'(c2 - c1), 32'd34);
        wait_result(lat);
        check("b2b_second_lt", 32'(less_than), 32'd1);
        check("b2b_second_eq", 32'(equals), 32'd0);

        // Result held in DONE while o_ready low and inputs churn
        @(posedge clk); #1;
        o_ready = 1'b0;
        start_cmp(32'hFFFF_FFFF, 32'h0000_0001, c1);
        wait_result(lat);
        e0 = 1'b0;
        l0 = SIGNED_BUILD;
        for (int k = 0; k < 5; k++) begin
            a = ~a; b = b + 32'd3; i_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("hold%0d_o_valid", k), 32'(o_valid), 32'd1);
            check($sformatf("hold%0d_i_ready", k), 32'(i_ready), 32'd0);
            check($sformatf("hold%0d_equals", k), 32'(equals), 32'(e0));
            check($sformatf("hold%0d_less_than", k), 32'(less_than), 32'(l0));
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_o_valid", 32'(o_valid), 32'd0);
        check("hold_release_i_ready", 32'(i_ready), 32'd1);
        check("hold_release_lt_held", 32'(less_than), 32'(l0));

        // Reset at bit 10 of a run abandons it
        start_cmp(32'd7, 32'd9, c1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_i_ready", 32'(i_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_o_valid", 32'(o_valid), 32'd0);
        check("midrst_less_than", 32'(less_than), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) saw_valid = 1'b1;
        end
        check("midrst_no_o_valid", 32'(saw_valid), 32'd0);
        start_cmp(32'd5, 32'd5, c1);
        wait_result(lat);
        check("after_rst_equals", 32'(equals), 32'd1);
        check("after_rst_less_than", 32'(less_than), 32'd0);

        // Random pairs against a behavioural reference
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 8)
                0:       rb = ra;
                1:       rb = ra ^ (32'd1 << $urandom_range(31, 0));
                default: rb = $urandom;
            endcase
            rexp = SIGNED_BUILD ? ($signed(ra) < $signed(rb)) : (ra < rb);
            start_cmp(ra, rb, c1);
            wait_result(lat);
            check($sformatf("rnd%0d_equals", i), 32'(equals), 32'(ra == rb));
            check($sformatf("rnd%0d_less_than", i), 32'(less_than), 32'(rexp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter N, default 32: operand width in bits, N >= 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_valid  input  1  operands a/b presented.
REQ-005 SHALL have port i_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  first operand.
REQ-007 SHALL have port b  input  N  second operand.
REQ-008 SHALL have port o_valid  output  1  result available.
REQ-009 SHALL have port o_ready  input  1  consumer takes result.
REQ-010 SHALL have port equals  output  1  a == b.
REQ-011 SHALL have port less_than  output  1  a < b, signed or unsigned per REQ-030.
REQ-012 SHALL have port busy  output  1  comparison in progress.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL drive i_ready high only in IDLE; busy high only in RUN; o_valid high only in DONE.
REQ-015 SHALL accept on the rising edge where i_ready & i_valid: latch a, b into shift registers, clear bit counter, set eq_acc=1, lt_acc=0, go to RUN.
REQ-016 SHALL in RUN process one bit per cycle, LSB first, with bit index 0..N-1 from an internal counter of width $clog2(N).
REQ-017 SHALL update per bit i < N-1: lt_acc <= (~a_i & b_i) | ((a_i ~^ b_i) & lt_acc); eq_acc <= eq_acc & (a_i ~^ b_i).
REQ-018 SHALL update at bit N-1 using the MSB rule of REQ-030, then go to DONE.
REQ-019 SHALL assert o_valid exactly N clock edges after the accepting edge: latency N cycles, plus 1 cycle back in IDLE before the next accept.
REQ-020 SHALL hold equals and less_than stable in DONE until the edge where o_ready is high, then return to IDLE.
REQ-021 SHALL ignore i_valid and any a/b changes outside IDLE, so operands are sampled only at accept.
REQ-022 SHALL hold the last result on equals/less_than in IDLE and RUN; these are qualified only by o_valid.
REQ-023 SHALL, when o_ready is already high on DONE entry, leave DONE after exactly one cycle.
REQ-024 SHALL never assert equals and less_than together when o_valid is high.

Reset
REQ-025 SHALL on rst low, asynchronously: state=IDLE, i_ready=1, o_valid=0, busy=0, equals=0, less_than=0, counter=0, shift registers=0.
REQ-026 SHALL abandon any comparison in progress on reset mid-RUN or mid-DONE, with no o_valid pulse.
REQ-027 SHALL accept a new operand on the first rising edge after rst deasserts if i_valid is high.

Configuration
REQ-028 SHALL use macro SERIAL_COMPARATOR_SIGNED_EN.
REQ-029 SHALL, with the macro defined, treat a and b as two's-complement signed.
REQ-030 SHALL apply the MSB rule at bit N-1: signed, lt = (a_i & ~b_i) | ((a_i ~^ b_i) & lt_acc); unsigned (macro undefined), the REQ-017 rule.

Structure
REQ-031 SHALL place the state enum (IDLE/RUN/DONE) and default width constant in package serial_comparator_pkg.
REQ-032 SHALL instantiate one combinational sub-module compare_bit with inputs a_i, b_i, eq_in, lt_in, msb and outputs eq_out, lt_out.

Verification (N=32, signed build unless noted)
REQ-033 SHALL cover a=0, b=0 -> o_valid after 32 cycles, equals=1, less_than=0.
REQ-034 SHALL cover a=-1, b=1 -> equals=0, less_than=1. In an unsigned build the same operands -> less_than=0.
REQ-035 SHALL cover a=38273, b=1000 -> less_than=0, equals=0; then a=1000, b=38273 back-to-back with o_ready held high -> less_than=1, second accept exactly 34 cycles after the first.
REQ-036 SHALL cover a=32'h80000000, b=32'h7FFFFFFF -> less_than=1 signed, 0 unsigned.
REQ-037 SHALL cover o_ready low for 5 cycles in DONE with a/b toggled meanwhile -> outputs stable, i_ready=0 throughout, then IDLE one cycle after o_ready is raised.
REQ-038 SHALL cover rst pulsed low at bit 10 of RUN -> immediate IDLE, no o_valid; a following a=b=5 compare -> equals=1. Plus 1000 random pairs checked against a behavioural reference.
